// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I datapath: a Moore FSM that walks each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath enables and selects.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic               InstrDone,
    output logic               Illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(11);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic [6:0]         op_reg;
    logic [2:0]         funct3_reg;
    logic               funct7b5_reg;
    logic               illegal_reg;
    logic               illegal_next;

    logic [2:0]         alu_decoded;
    logic               alu_bad;
    logic               branch_ok;
    logic               pc_write_raw;
    logic               mem_write_raw;
    logic               ir_write_raw;
    logic               reg_write_raw;

    // ALU operation from the latched fields; only R-type may select sub on funct3=000
    always_comb begin
        alu_decoded = ALU_ADD;
        alu_bad     = 1'b0;
        case (funct3_reg)
            3'b000:  alu_decoded = (op_reg == OP_R && funct7b5_reg) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decoded = ALU_SLT;
            3'b110:  alu_decoded = ALU_OR;
            3'b111:  alu_decoded = ALU_AND;
            default: begin
                alu_decoded = ALU_ADD;
                alu_bad     = 1'b1;
            end
        endcase
    end

    assign branch_ok = (funct3_reg[2:1] == 2'b00);

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op_reg)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BR:        state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR:   state_next = (op_reg == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        illegal_next = illegal_reg;
        case (state_reg)
            S_DECODE: begin
                if (!(op_reg == OP_LW || op_reg == OP_SW || op_reg == OP_R ||
                      op_reg == OP_I  || op_reg == OP_BR || op_reg == OP_JAL)) begin
                    illegal_next = 1'b1;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                if (alu_bad) begin
                    illegal_next = 1'b1;
                end
            end
            S_BRANCH: begin
                if (!branch_ok) begin
                    illegal_next = 1'b1;
                end
            end
            S_HALT:  illegal_next = 1'b1;
            default: illegal_next = illegal_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            op_reg       <= 7'd0;
            funct3_reg   <= 3'd0;
            funct7b5_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            if (state_reg == S_FETCH) begin
                op_reg       <= op;
                funct3_reg   <= funct3;
                funct7b5_reg <= funct7b5;
            end
        end
    end

    // Moore outputs; the branch PC enable is the one term that looks at a live input (Zero)
    always_comb begin
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ImmSrc        = 2'b00;
        ALUControl    = ALU_ADD;
        InstrDone     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op_reg == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                InstrDone     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                InstrDone     = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decoded;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decoded;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                InstrDone     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUControl   = ALU_SUB;
                InstrDone    = 1'b1;
                pc_write_raw = branch_ok & (Zero ^ funct3_reg[0]);
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: begin
                pc_write_raw = 1'b0;
            end
        endcase
    end

    // Reset masks every architectural write so an abandoned instruction leaves no trace
    assign PCWrite   = pc_write_raw  & ~reset;
    assign MemWrite  = mem_write_raw & ~reset;
    assign IRWrite   = ir_write_raw  & ~reset;
    assign RegWrite  = reg_write_raw & ~reset;
    assign Illegal   = illegal_reg;
    assign dbg_state = state_reg;

endmodule
